// File: rtl/yrc_pkg.sv
// Shared types, defaults and the signature step for the y response capture block.
package yrc_pkg;

    localparam int          Y_WIDTH_DEFAULT  = 240;
    localparam int          BYTES_PER_WORD   = Y_WIDTH_DEFAULT / 8;
    localparam logic [31:0] SIG_POLY_DEFAULT = 32'h04C11DB7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } yrc_state_e;

    // One LFSR-style fold of a transferred byte into the running signature.
    function automatic logic [31:0] sig_step(input logic [31:0] sig,
                                             input logic [7:0]  data,
                                             input logic [31:0] poly);
        logic [31:0] fb;
        fb = sig[31] ? poly : 32'h0000_0000;
        return ((sig << 1) ^ fb) ^ {24'h00_0000, data};
    endfunction

endpackage

// File: rtl/y_response_capture_if.sv
// Capture-side bus: sampled result input, byte stream output and run statistics.
interface y_response_capture_if
    import yrc_pkg::*;
#(
    parameter int Y_WIDTH = Y_WIDTH_DEFAULT
) ();
    logic               sample_en;
    logic [Y_WIDTH-1:0] y;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic [31:0]        sig;
    logic               overflow;
    logic [7:0]         drop_count;
    logic [15:0]        word_count;

    modport master (
        input  sample_en, y, out_ready,
        output out_data, out_valid, out_last, sig, overflow, drop_count, word_count
    );

    modport slave (
        output sample_en, y, out_ready,
        input  out_data, out_valid, out_last, sig, overflow, drop_count, word_count
    );
endinterface

// File: rtl/yrc_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit so full/empty need no counter.
module yrc_fifo
    import yrc_pkg::*;
#(
    parameter int WIDTH = Y_WIDTH_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_en;
    logic             w_rd_en;

    assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign w_wr_en = push & ~full;
    assign w_rd_en = pop & ~empty;
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; occupancy is judged on pre-edge state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array, no reset needed on data.
    always_ff @(posedge clk) begin
        if (w_wr_en && rst_n) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end
endmodule

// File: rtl/y_response_capture.sv
// Captures the result bus on sample_en, queues it and streams it MSB-first as bytes,
// folding every accepted byte into a 32-bit signature.
module y_response_capture
    import yrc_pkg::*;
#(
    parameter int          Y_WIDTH  = Y_WIDTH_DEFAULT,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] SIG_POLY = SIG_POLY_DEFAULT
) (
    input logic                  clk,
    input logic                  rst_n,
    y_response_capture_if.master bus
);
    localparam int            BPW      = Y_WIDTH / 8;
    localparam int            IW       = $clog2(BPW + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(BPW - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    yrc_state_e         r_state;
    logic               r_cap_vld;
    logic [Y_WIDTH-1:0] r_cap_data;
    logic [Y_WIDTH-1:0] r_shift;
    logic [IW-1:0]      r_idx;
    logic               r_valid;
    logic               r_last;
    logic [31:0]        r_sig;
    logic               r_overflow;
    logic [7:0]         r_drop;
    logic [15:0]        r_words;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [Y_WIDTH-1:0] w_head;

    assign w_push = r_cap_vld & ~w_full;
    assign w_pop  = (r_state == IDLE) & ~w_empty;

    yrc_fifo #(
        .WIDTH (Y_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .wr_data (r_cap_data),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign bus.out_data   = r_shift[Y_WIDTH-1 -: 8];
    assign bus.out_valid  = r_valid;
    assign bus.out_last   = r_last;
    assign bus.sig        = r_sig;
    assign bus.overflow   = r_overflow;
    assign bus.drop_count = r_drop;
    assign bus.word_count = r_words;

    // Capture stage, drop accounting and the IDLE/SEND serializer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cap_vld  <= 1'b0;
            r_cap_data <= '0;
            r_shift    <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_sig      <= 32'h0000_0000;
            r_overflow <= 1'b0;
            r_drop     <= 8'h00;
            r_words    <= 16'h0000;
        end else begin
            r_cap_vld  <= bus.sample_en;
            r_cap_data <= bus.y;
            if (r_cap_vld && w_full) begin
                r_overflow <= 1'b1;
                if (r_drop != 8'hFF) begin
                    r_drop <= r_drop + 8'd1;
                end
            end
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_idx   <= {IW{1'b0}};
                        r_valid <= 1'b1;
                        r_last  <= (LAST_IDX == {IW{1'b0}});
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        r_shift <= {r_shift[Y_WIDTH-9:0], 8'h00};
                        r_idx   <= r_idx + IDX_ONE;
                        r_sig   <= sig_step(r_sig, r_shift[Y_WIDTH-1 -: 8], SIG_POLY);
                        if (r_last) begin
                            r_words <= r_words + 16'd1;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_last  <= ((r_idx + IDX_ONE) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_y_response_capture.sv
// Directed self-checking bench for y_response_capture (240-bit bus, depth 4).
module tb_y_response_capture;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    logic [31:0]  m_sig;
    logic [239:0] w_ab;
    logic [239:0] w_bp;
    logic [239:0] w_rs;
    logic [239:0] ow [8];

    y_response_capture_if #(.Y_WIDTH(240)) bus ();

    y_response_capture #(
        .Y_WIDTH  (240),
        .DEPTH    (4),
        .SIG_POLY (32'h04C11DB7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [239:0] obs, input logic [239:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sig_next(input logic [31:0] s, input logic [7:0] b);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ {24'h0, b};
    endfunction

    // Receive nbytes of a word; optionally stall 10 cycles before byte stall_at.
    task automatic recv(input logic [239:0] exp, input int nbytes, input int stall_at, input string tag);
        logic [239:0] got;
        logic [29:0]  lastv;
        logic [7:0]   hd;
        logic         hl;
        logic         stable;
        logic         allv;
        int           wait_n;
        got    = '0;
        lastv  = '0;
        stable = 1'b1;
        allv   = 1'b1;
        hd     = 8'h00;
        hl     = 1'b0;
        bus.out_ready = 1'b1;
        wait_n = 0;
        while (bus.out_valid !== 1'b1 && wait_n < 200) begin
            tick();
            wait_n++;
        end
        chk({tag, "_valid_wait"}, 240'(bus.out_valid), 240'd1);
        for (int k = 0; k < nbytes; k++) begin
            if (k == stall_at) begin
                bus.out_ready = 1'b0;
                hd = bus.out_data;
                hl = bus.out_last;
                for (int s = 0; s < 10; s++) begin
                    tick();
                    if (bus.out_valid !== 1'b1 || bus.out_data !== hd || bus.out_last !== hl)
                        stable = 1'b0;
                end
                bus.out_ready = 1'b1;
            end
            if (bus.out_valid !== 1'b1) allv = 1'b0;
            got = {got[231:0], bus.out_data};
            lastv[29-k] = bus.out_last;
            m_sig = sig_next(m_sig, bus.out_data);
            tick();
        end
        chk({tag, "_bytes"}, got, exp >> (240 - 8 * nbytes));
        chk({tag, "_last"}, 240'(lastv), (nbytes == 30) ? 240'd1 : 240'd0);
        chk({tag, "_allvalid"}, 240'(allv), 240'd1);
        if (stall_at >= 0) chk({tag, "_stall_stable"}, 240'(stable), 240'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m_sig = 32'h0;
        rst_n = 1'b0;
        bus.sample_en = 1'b1;
        bus.y = {240{1'b1}};
        bus.out_ready = 1'b1;

        // Reset with sampling requested
        tick(); tick(); tick();
        chk("rst_valid", 240'(bus.out_valid), 240'd0);
        chk("rst_sig", 240'(bus.sig), 240'd0);
        chk("rst_ovf", 240'(bus.overflow), 240'd0);
        chk("rst_drop", 240'(bus.drop_count), 240'd0);
        chk("rst_words", 240'(bus.word_count), 240'd0);
        chk("rst_data", 240'(bus.out_data), 240'd0);
        rst_n = 1'b1;
        bus.sample_en = 1'b0;
        tick(); tick(); tick(); tick();
        chk("rst_fifo_empty", 240'(bus.out_valid), 240'd0);

        // Basic transfer: zero word then 1
        bus.sample_en = 1'b1;
        bus.y = 240'h0;
        tick();
        bus.y = 240'h1;
        tick();
        bus.sample_en = 1'b0;
        chk("basic_lat_n1", 240'(bus.out_valid), 240'd0);
        recv(240'h0, 30, -1, "basic_w0");
        chk("basic_sig0", 240'(bus.sig), 240'h0);
        recv(240'h1, 30, -1, "basic_w1");
        chk("basic_sig1", 240'(bus.sig), 240'h1);
        chk("basic_words", 240'(bus.word_count), 240'd2);

        // Byte order and latency
        w_ab = '0;
        w_ab[239:232] = 8'hAB;
        bus.sample_en = 1'b1;
        bus.y = w_ab;
        tick();
        bus.sample_en = 1'b0;
        tick();
        chk("order_lat_n1", 240'(bus.out_valid), 240'd0);
        tick();
        chk("order_lat_n2", 240'(bus.out_valid), 240'd1);
        chk("order_first", 240'(bus.out_data), 240'hAB);
        recv(w_ab, 30, -1, "order");
        chk("order_sig", 240'(bus.sig), 240'(m_sig));

        // Backpressure mid-word
        w_bp = '0;
        for (int k = 0; k < 30; k++) w_bp[239 - 8 * k -: 8] = 8'(k + 1);
        bus.sample_en = 1'b1;
        bus.y = w_bp;
        tick();
        bus.sample_en = 1'b0;
        recv(w_bp, 30, 7, "bp");
        chk("bp_sig", 240'(bus.sig), 240'(m_sig));
        chk("bp_words", 240'(bus.word_count), 240'd4);

        // Overflow: fresh reset, 8 back-to-back samples with no consumer
        rst_n = 1'b0;
        m_sig = 32'h0;
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ow[i] = '0;
            ow[i][239:232] = 8'(i + 1);
            ow[i][7:0] = 8'(8'hF0 + i);
        end
        for (int i = 0; i < 8; i++) begin
            bus.sample_en = 1'b1;
            bus.y = ow[i];
            tick();
        end
        bus.sample_en = 1'b0;
        tick(); tick();
        chk("ovf_drop", 240'(bus.drop_count), 240'd3);
        chk("ovf_flag", 240'(bus.overflow), 240'd1);
        for (int i = 0; i < 5; i++) recv(ow[i], 30, -1, $sformatf("ovf_w%0d", i + 1));
        chk("ovf_words", 240'(bus.word_count), 240'd5);
        chk("ovf_sig", 240'(bus.sig), 240'(m_sig));
        tick(); tick(); tick();
        chk("ovf_drained", 240'(bus.out_valid), 240'd0);

        // Reset mid-word after 12 bytes
        bus.sample_en = 1'b1;
        bus.y = w_bp;
        tick();
        bus.sample_en = 1'b0;
        recv(w_bp, 12, -1, "rmid_part");
        rst_n = 1'b0;
        m_sig = 32'h0;
        tick();
        chk("rmid_valid", 240'(bus.out_valid), 240'd0);
        chk("rmid_sig", 240'(bus.sig), 240'd0);
        chk("rmid_words", 240'(bus.word_count), 240'd0);
        rst_n = 1'b1;
        tick(); tick();
        chk("rmid_idle", 240'(bus.out_valid), 240'd0);
        w_rs = ~w_bp;
        bus.sample_en = 1'b1;
        bus.y = w_rs;
        tick();
        bus.sample_en = 1'b0;
        recv(w_rs, 30, -1, "rmid_restart");
        chk("rmid_words1", 240'(bus.word_count), 240'd1);
        chk("rmid_sig1", 240'(bus.sig), 240'(m_sig));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
